cache_axi_arbitrater: RTL and testbench
=======================================

# cache_axi_arbitrater

Responder for the cache-side request interface of the instruction and data caches. It accepts one pending instruction request and one pending data request, serialises them onto a single AXI3 master port, and returns read data with a one-cycle `dok` pulse per request. It drives the pipeline-wide `stall_by_arbitrater` until every asserted request of the current cycle has been served.

## Interface
Parameters: none. Constants are taken from the shared package.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `resetn`  in  1  reset; synchronous, active-low.
- `stall_by_arbitrater`  out  1  high while any asserted request is unserved.
- `inst_cache_req`/`data_cache_req`  in  1  level request, held with its fields until served.
- `inst_cache_addr`/`data_cache_addr`  in  32  byte address.
- `inst_cache_wr`/`data_cache_wr`  in  1  1 = write.
- `inst_cache_size`/`data_cache_size`  in  2  00 byte, 01 half, 10 word.
- `inst_cache_wdata`/`data_cache_wdata`  in  32  write data, lane-aligned.
- `inst_cache_rdata`/`data_cache_rdata`  out  32  registered read data, held until the next read on the same side.
- `inst_cache_dok`/`data_cache_dok`  out  1  one-cycle done pulse.
- `arid,araddr,arsize,arvalid` / `arready`  out / in  4,32,3,1 / 1  AXI read address.
- `rid,rdata,rresp,rlast,rvalid` / `rready`  in / out  4,32,2,1,1 / 1  AXI read data.
- `awid,awaddr,awsize,awvalid` / `awready`  out / in  4,32,3,1 / 1  AXI write address.
- `wid,wdata,wstrb,wlast,wvalid` / `wready`  out / in  4,32,4,1,1 / 1  AXI write data.
- `bid,bresp,bvalid` / `bready`  in / out  4,2,1 / 1  AXI write response.
- `arlen,arburst,arlock,arcache,arprot,awlen,awburst,awlock,awcache,awprot`  out  constants: len 0, burst INCR, others 0.

## Operation
- FSM states: IDLE, RADDR, RDATA, WADDR, WRESP.
- Pending flags:
  - `inst_pend = inst_cache_req & ~inst_done`
  - `data_pend = data_cache_req & ~data_done`
  - `stall_by_arbitrater = inst_pend | data_pend` (combinational).
- IDLE: if `data_pend`, serve data first; otherwise, if `inst_pend`, serve inst.
  - Latch the selected addr, size, wdata and side into a request register.
  - Go to RADDR if `wr=0`, or WADDR if `wr=1`.
- RADDR: `arvalid=1` with the latched addr. `arid` is 0 for inst and 1 for data. On `arready`, go to RDATA.
- RDATA: `rready=1`. On `rvalid`:
  - capture `rdata` into the side's buffer;
  - set the side's `done` flag;
  - pulse the side's `dok` on the next cycle;
  - go to IDLE.
- WADDR: `awvalid` and `wvalid` are asserted together. Each drops independently after its own handshake. When both handshakes are complete, go to WRESP.
- WRESP: `bready=1`. On `bvalid`, set `done`, pulse `dok` next cycle, and go to IDLE.
- Write strobe generation:
  - size 00: `wstrb = 1<<addr[1:0]`
  - size 01: `wstrb = addr[1] ? 1100 : 0011`
  - size 10: `wstrb = 1111`
- `arsize`/`awsize` = {0, size}. `wlast=1`.
- Done flags clear on any edge where `stall_by_arbitrater=0`, because the pipeline advances at that edge.
- `rresp`/`bresp` are ignored; errors are not reported.

## Timing
- Reset values: all valid/ready outputs 0, dok 0, rdata buffers 0, done flags 0, FSM in IDLE.
- Zero-wait-state read: req seen at cycle 0 → arvalid at 1 → R handshake at 2 → dok and stall low at 3.
- Simultaneous inst and data requests: data completes first. Inst starts on the cycle after data returns to IDLE. Stall stays high until inst is done.
- The `dok` cycle is the first cycle with `done=1`. Stall falls in that same cycle only if the other side is not pending.
- A request that drops before it is served is ignored once the FSM is back in IDLE. A transaction already issued is always completed.
- Reset asserted mid-transaction abandons it. The bench must reset the AXI slave as well.

## Configuration
- `CACHE_AXI_EARLY_WACK_EN` defined:
  - write `done`/`dok` fire on completion of the AW+W handshakes, and the FSM returns to IDLE immediately;
  - a `b_pending` flag with `bready=1` absorbs the later `bvalid`;
  - no new AR or AW is issued while `b_pending=1`.
- Not defined: a write completes only on `bvalid` (WRESP state is used).

## Structure
- Shared package holds:
  - the FSM state enum;
  - ID constants (INST_ID=0, DATA_ID=1);
  - the size encodings;
  - AXI tie-off constants.
- One sub-module, `axi_wstrb_gen`, holds the combinational size/offset → wstrb logic.

## Test plan
- Inst read at 0xBFC00000, slave returns 0x3C080001 with 0 waits → `inst_cache_dok` at cycle 3, rdata 0x3C080001, stall high for cycles 0–2.
- Same-cycle inst read and data read → AR order is data (arid 1) then inst (arid 0). Each side gets its own dok. Stall drops only after the inst dok.
- Data byte write, addr 0x80000003, wdata 0xAB000000 → wstrb 1000, awsize 000. dok arrives only after bvalid (macro off).
- Half write at addr 0x80000002 → wstrb 1100. Word write → wstrb 1111.
- Slave holds arready low for 5 cycles → arvalid and araddr stay stable, and stall stays high throughout.
- `CACHE_AXI_EARLY_WACK_EN` defined, write followed by an immediate read, bvalid delayed 4 cycles → write dok arrives before bvalid, and the read's arvalid is withheld until bvalid.
- resetn low during RDATA → all outputs at reset values on the next edge. After release, a new read completes normally.

Source files
------------

// File: rtl/cache_axi_arbitrater_pkg.sv
// rtl/cache_axi_arbitrater_pkg.sv - shared states, AXI IDs, size codes and tie-offs for cache_axi_arbitrater
package cache_axi_arbitrater_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RADDR,
        RDATA,
        WADDR,
        WRESP
    } arb_state_t;

    localparam logic [3:0] INST_ID = 4'd0;
    localparam logic [3:0] DATA_ID = 4'd1;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic [3:0] AXI_LEN_SINGLE = 4'd0;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_LOCK_NONE  = 2'b00;
    localparam logic [3:0] AXI_CACHE_NONE = 4'b0000;
    localparam logic [2:0] AXI_PROT_NONE  = 3'b000;

endpackage

// File: rtl/cache_axi_arbitrater_wstrb_gen.sv
// rtl/cache_axi_arbitrater_wstrb_gen.sv - byte-lane strobe from access size and address offset
module axi_wstrb_gen
    import cache_axi_arbitrater_pkg::*;
(
    input  logic [1:0] i_size,
    input  logic [1:0] i_offset,
    output logic [3:0] o_wstrb
);

    always_comb begin
        o_wstrb = 4'b1111;
        case (i_size)
            SIZE_BYTE: o_wstrb = 4'b0001 << i_offset;
            SIZE_HALF: o_wstrb = i_offset[1] ? 4'b1100 : 4'b0011;
            default:   o_wstrb = 4'b1111;
        endcase
    end

endmodule

// File: rtl/cache_axi_arbitrater.sv
// rtl/cache_axi_arbitrater.sv - serialises inst/data cache requests onto one AXI3 master port
// Optional macro CACHE_AXI_EARLY_WACK_EN: acknowledge writes on AW+W completion, absorb B later.
module cache_axi_arbitrater
    import cache_axi_arbitrater_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    output logic        stall_by_arbitrater,

    input  logic        inst_cache_req,
    input  logic [31:0] inst_cache_addr,
    input  logic        inst_cache_wr,
    input  logic [1:0]  inst_cache_size,
    input  logic [31:0] inst_cache_wdata,
    output logic [31:0] inst_cache_rdata,
    output logic        inst_cache_dok,

    input  logic        data_cache_req,
    input  logic [31:0] data_cache_addr,
    input  logic        data_cache_wr,
    input  logic [1:0]  data_cache_size,
    input  logic [31:0] data_cache_wdata,
    output logic [31:0] data_cache_rdata,
    output logic        data_cache_dok,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,

    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,

    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,

    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    arb_state_t  r_state, w_next;
    logic [31:0] r_addr, r_wdata;
    logic [1:0]  r_size;
    logic        r_side;
    logic        r_inst_done, r_data_done, r_inst_dok, r_data_dok;
    logic [31:0] r_inst_rdata, r_data_rdata;
    logic        r_aw_done, r_w_done;
    logic        w_inst_pend, w_data_pend, w_finish, w_bready_fsm;
    logic        w_issue_block, w_b_absorb, w_unused;

    assign w_inst_pend         = inst_cache_req & ~r_inst_done;
    assign w_data_pend         = data_cache_req & ~r_data_done;
    assign stall_by_arbitrater = w_inst_pend | w_data_pend;

`ifdef CACHE_AXI_EARLY_WACK_EN
    logic r_b_pending;

    always_ff @(posedge clk) begin
        if (!resetn)
            r_b_pending <= 1'b0;
        else if (r_state == WADDR && w_next == IDLE)
            r_b_pending <= 1'b1;
        else if (bvalid)
            r_b_pending <= 1'b0;
    end

    assign w_issue_block = r_b_pending;
    assign w_b_absorb    = r_b_pending;
`else
    assign w_issue_block = 1'b0;
    assign w_b_absorb    = 1'b0;
`endif

    // Data side wins in IDLE; w_finish marks the cycle a transaction retires.
    always_comb begin
        w_next       = r_state;
        w_finish     = 1'b0;
        arvalid      = 1'b0;
        rready       = 1'b0;
        awvalid      = 1'b0;
        wvalid       = 1'b0;
        w_bready_fsm = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_issue_block) begin
                    if (w_data_pend)
                        w_next = data_cache_wr ? WADDR : RADDR;
                    else if (w_inst_pend)
                        w_next = inst_cache_wr ? WADDR : RADDR;
                end
            end
            RADDR: begin
                arvalid = 1'b1;
                if (arready)
                    w_next = RDATA;
            end
            RDATA: begin
                rready = 1'b1;
                if (rvalid) begin
                    w_finish = 1'b1;
                    w_next   = IDLE;
                end
            end
            WADDR: begin
                awvalid = ~r_aw_done;
                wvalid  = ~r_w_done;
                if ((r_aw_done | awready) & (r_w_done | wready)) begin
`ifdef CACHE_AXI_EARLY_WACK_EN
                    w_finish = 1'b1;
                    w_next   = IDLE;
`else
                    w_next   = WRESP;
`endif
                end
            end
            WRESP: begin
                w_bready_fsm = 1'b1;
                if (bvalid) begin
                    w_finish = 1'b1;
                    w_next   = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_size       <= '0;
            r_wdata      <= '0;
            r_side       <= 1'b0;
            r_inst_done  <= 1'b0;
            r_data_done  <= 1'b0;
            r_inst_dok   <= 1'b0;
            r_data_dok   <= 1'b0;
            r_inst_rdata <= '0;
            r_data_rdata <= '0;
            r_aw_done    <= 1'b0;
            r_w_done     <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_inst_dok <= w_finish & ~r_side;
            r_data_dok <= w_finish & r_side;

            if (r_state == IDLE && w_next != IDLE) begin
                r_side  <= w_data_pend;
                r_addr  <= w_data_pend ? data_cache_addr  : inst_cache_addr;
                r_size  <= w_data_pend ? data_cache_size  : inst_cache_size;
                r_wdata <= w_data_pend ? data_cache_wdata : inst_cache_wdata;
            end

            if (r_state == WADDR && w_next == WADDR) begin
                r_aw_done <= r_aw_done | awready;
                r_w_done  <= r_w_done | wready;
            end else begin
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end

            if (r_state == RDATA && rvalid) begin
                if (r_side)
                    r_data_rdata <= rdata;
                else
                    r_inst_rdata <= rdata;
            end

            // The pipeline advances on any edge with stall low, retiring both done flags.
            if (w_finish && !r_side)
                r_inst_done <= 1'b1;
            else if (!stall_by_arbitrater)
                r_inst_done <= 1'b0;

            if (w_finish && r_side)
                r_data_done <= 1'b1;
            else if (!stall_by_arbitrater)
                r_data_done <= 1'b0;
        end
    end

    axi_wstrb_gen u_wstrb_gen (
        .i_size   (r_size),
        .i_offset (r_addr[1:0]),
        .o_wstrb  (wstrb)
    );

    assign inst_cache_rdata = r_inst_rdata;
    assign data_cache_rdata = r_data_rdata;
    assign inst_cache_dok   = r_inst_dok;
    assign data_cache_dok   = r_data_dok;

    assign arid    = r_side ? DATA_ID : INST_ID;
    assign awid    = arid;
    assign wid     = arid;
    assign araddr  = r_addr;
    assign awaddr  = r_addr;
    assign arsize  = {1'b0, r_size};
    assign awsize  = {1'b0, r_size};
    assign wdata   = r_wdata;
    assign wlast   = 1'b1;
    assign bready  = w_bready_fsm | w_b_absorb;

    assign arlen   = AXI_LEN_SINGLE;
    assign awlen   = AXI_LEN_SINGLE;
    assign arburst = AXI_BURST_INCR;
    assign awburst = AXI_BURST_INCR;
    assign arlock  = AXI_LOCK_NONE;
    assign awlock  = AXI_LOCK_NONE;
    assign arcache = AXI_CACHE_NONE;
    assign awcache = AXI_CACHE_NONE;
    assign arprot  = AXI_PROT_NONE;
    assign awprot  = AXI_PROT_NONE;

    // Response IDs and error codes carry no information for a single-outstanding master.
    assign w_unused = ^{rid, rresp, rlast, bid, bresp};

endmodule

// File: tb/tb_cache_axi_arbitrater.sv
// tb/tb_cache_axi_arbitrater.sv - directed scoreboard bench for cache_axi_arbitrater
`timescale 1ns/1ps
module tb_cache_axi_arbitrater;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn, stall_by_arbitrater;
    logic        inst_cache_req, inst_cache_wr, inst_cache_dok;
    logic [31:0] inst_cache_addr, inst_cache_wdata, inst_cache_rdata;
    logic [1:0]  inst_cache_size;
    logic        data_cache_req, data_cache_wr, data_cache_dok;
    logic [31:0] data_cache_addr, data_cache_wdata, data_cache_rdata;
    logic [1:0]  data_cache_size;
    logic [3:0]  arid, arlen, arcache, awid, awlen, awcache, wid, wstrb, rid, bid;
    logic [31:0] araddr, awaddr, wdata, rdata;
    logic [2:0]  arsize, arprot, awsize, awprot;
    logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    cache_axi_arbitrater dut (
        .clk(clk), .resetn(resetn), .stall_by_arbitrater(stall_by_arbitrater),
        .inst_cache_req(inst_cache_req), .inst_cache_addr(inst_cache_addr), .inst_cache_wr(inst_cache_wr),
        .inst_cache_size(inst_cache_size), .inst_cache_wdata(inst_cache_wdata),
        .inst_cache_rdata(inst_cache_rdata), .inst_cache_dok(inst_cache_dok),
        .data_cache_req(data_cache_req), .data_cache_addr(data_cache_addr), .data_cache_wr(data_cache_wr),
        .data_cache_size(data_cache_size), .data_cache_wdata(data_cache_wdata),
        .data_cache_rdata(data_cache_rdata), .data_cache_dok(data_cache_dok),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
        .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
        .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    typedef struct { logic [3:0] id; logic [31:0] addr; logic [2:0] size; } ar_exp_t;
    typedef struct { logic [3:0] id; logic [31:0] addr; logic [2:0] size; logic [3:0] strb; logic [31:0] data; } w_exp_t;
    typedef struct { bit side; bit rd; logic [31:0] data; } dok_exp_t;

    ar_exp_t  exp_ar[$];
    w_exp_t   exp_w[$];
    dok_exp_t exp_dok[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int ar_wait = 0, r_wait = 0, b_wait = 0;
    int last_b_cyc = -1, last_ar_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        return a ^ 32'h83C8_0001;
    endfunction

    // Drive a level request and push what the bus and the cache side should later see.
    task automatic issue(input bit side, input logic [31:0] addr, input bit wr, input logic [1:0] size,
                         input logic [31:0] wd, input logic [3:0] strb, input logic [31:0] exp_rd);
        ar_exp_t a; w_exp_t w; dok_exp_t d;
        if (wr) begin
            w.id = {3'b000, side}; w.addr = addr; w.size = {1'b0, size}; w.strb = strb; w.data = wd;
            exp_w.push_back(w);
        end else begin
            a.id = {3'b000, side}; a.addr = addr; a.size = {1'b0, size};
            exp_ar.push_back(a);
        end
        d.side = side; d.rd = !wr; d.data = exp_rd;
        exp_dok.push_back(d);
        if (side) begin
            data_cache_req = 1'b1; data_cache_addr = addr; data_cache_wr = wr;
            data_cache_size = size; data_cache_wdata = wd;
        end else begin
            inst_cache_req = 1'b1; inst_cache_addr = addr; inst_cache_wr = wr;
            inst_cache_size = size; inst_cache_wdata = wd;
        end
        #1;
    endtask

    task automatic wait_dok(input bit side, input int limit, output int at);
        bit got = 1'b0;
        at = -1;
        for (int i = 0; i < limit && !got; i++) begin
            @(negedge clk);
            if (side ? data_cache_dok : inst_cache_dok) begin
                got = 1'b1;
                at  = cyc;
            end
        end
        chk(side ? "data_dok_timeout" : "inst_dok_timeout", {31'd0, got}, 32'd1);
    endtask

    // AXI slave with per-channel wait knobs plus the scoreboard comparisons.
    initial begin : slave
        bit s_ar, s_r, s_aw, s_w, s_b, r_pend, b_pend, aw_got, w_got;
        int ar_cnt, r_cnt, b_cnt;
        logic [3:0] s_arid, s_awid;
        logic [31:0] s_araddr;
        ar_exp_t ea; w_exp_t ew; dok_exp_t ed;
        arready = 0; rvalid = 0; rid = 0; rdata = 0; rresp = 0; rlast = 1;
        awready = 0; wready = 0; bvalid = 0; bid = 0; bresp = 0;
        r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0; ar_cnt = 0; r_cnt = 0; b_cnt = 0;
        s_arid = 0; s_awid = 0; s_araddr = 0;
        forever begin
            @(negedge clk);
            s_ar = arvalid & arready; s_r = rvalid & rready;
            s_aw = awvalid & awready; s_w = wvalid & wready; s_b = bvalid & bready;
            if (s_ar) begin
                s_arid = arid; s_araddr = araddr; last_ar_cyc = cyc;
                chk("ar_expected", {31'd0, exp_ar.size() != 0}, 32'd1);
                if (exp_ar.size() != 0) begin
                    ea = exp_ar.pop_front();
                    chk("arid", {28'd0, arid}, {28'd0, ea.id});
                    chk("araddr", araddr, ea.addr);
                    chk("arsize", {29'd0, arsize}, {29'd0, ea.size});
                end
            end
            if (s_aw) begin
                s_awid = awid;
                chk("aw_expected", {31'd0, exp_w.size() != 0}, 32'd1);
                if (exp_w.size() != 0) begin
                    ew = exp_w.pop_front();
                    chk("awid", {28'd0, awid}, {28'd0, ew.id});
                    chk("awaddr", awaddr, ew.addr);
                    chk("awsize", {29'd0, awsize}, {29'd0, ew.size});
                    if (s_w) begin
                        chk("wstrb", {28'd0, wstrb}, {28'd0, ew.strb});
                        chk("wdata", wdata, ew.data);
                        chk("wlast", {31'd0, wlast}, 32'd1);
                    end
                end
            end
            if (s_b) last_b_cyc = cyc;
            if (inst_cache_dok || data_cache_dok) begin
                chk("dok_expected", {31'd0, exp_dok.size() != 0}, 32'd1);
                if (exp_dok.size() != 0) begin
                    ed = exp_dok.pop_front();
                    chk("dok_side", {31'd0, data_cache_dok}, {31'd0, ed.side});
                    if (ed.rd)
                        chk("dok_rdata", ed.side ? data_cache_rdata : inst_cache_rdata, ed.data);
                end
            end
            @(posedge clk);
            #1;
            if (!resetn) begin
                arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
                r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0; ar_cnt = 0; r_cnt = 0; b_cnt = 0;
            end else begin
                awready = 1; wready = 1;
                if (s_r) begin rvalid = 0; r_pend = 0; end
                if (s_ar) begin
                    arready = 0; ar_cnt = 0; r_pend = 1; r_cnt = 0;
                end else if (arvalid && !arready) begin
                    if (ar_cnt >= ar_wait) arready = 1; else ar_cnt++;
                end
                if (r_pend && !rvalid) begin
                    if (r_cnt >= r_wait) begin
                        rvalid = 1; rid = s_arid; rdata = rd_model(s_araddr);
                    end else r_cnt++;
                end
                if (s_b) begin bvalid = 0; b_pend = 0; end
                if (s_aw) aw_got = 1;
                if (s_w) w_got = 1;
                if (aw_got && w_got) begin aw_got = 0; w_got = 0; b_pend = 1; b_cnt = 0; bid = s_awid; end
                if (b_pend && !bvalid) begin
                    if (b_cnt >= b_wait) bvalid = 1; else b_cnt++;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        logic [31:0] wr_addr[3];
        logic [1:0]  wr_size[3];
        logic [3:0]  wr_strb[3];
        int at, at_w, bad_stall;
        bit got, seen_data;
        wr_addr[0] = 32'h8000_0002; wr_size[0] = 2'b01; wr_strb[0] = 4'b1100;
        wr_addr[1] = 32'h8000_0004; wr_size[1] = 2'b10; wr_strb[1] = 4'b1111;
        wr_addr[2] = 32'h8000_0010; wr_size[2] = 2'b01; wr_strb[2] = 4'b0011;

        resetn = 0;
        inst_cache_req = 0; inst_cache_addr = 0; inst_cache_wr = 0; inst_cache_size = 0; inst_cache_wdata = 0;
        data_cache_req = 0; data_cache_addr = 0; data_cache_wr = 0; data_cache_size = 0; data_cache_wdata = 0;
        repeat (3) @(negedge clk);
        chk("rst_arvalid", {31'd0, arvalid}, 0);
        chk("rst_awvalid_wvalid", {30'd0, awvalid, wvalid}, 0);
        chk("rst_rready_bready", {30'd0, rready, bready}, 0);
        chk("rst_dok", {30'd0, inst_cache_dok, data_cache_dok}, 0);
        chk("rst_inst_rdata", inst_cache_rdata, 0);
        chk("rst_data_rdata", data_cache_rdata, 0);
        chk("rst_stall", {31'd0, stall_by_arbitrater}, 0);
        chk("tieoff_len_burst", {26'd0, arlen, arburst}, {26'd0, 4'd0, 2'b01});
        resetn = 1;

        // Zero-wait inst read: dok and stall low three cycles after the request.
        @(negedge clk);
        issue(0, 32'hBFC0_0000, 0, 2'b10, 0, 0, 32'h3C08_0001);
        chk("t1_c0_stall", {31'd0, stall_by_arbitrater}, 1);
        @(negedge clk);
        chk("t1_c1_arvalid", {31'd0, arvalid}, 1);
        chk("t1_c1_stall", {31'd0, stall_by_arbitrater}, 1);
        @(negedge clk);
        chk("t1_c2_rready", {31'd0, rready}, 1);
        chk("t1_c2_stall", {31'd0, stall_by_arbitrater}, 1);
        chk("t1_c2_no_dok", {31'd0, inst_cache_dok}, 0);
        @(negedge clk);
        chk("t1_c3_dok", {31'd0, inst_cache_dok}, 1);
        chk("t1_c3_rdata", inst_cache_rdata, 32'h3C08_0001);
        chk("t1_c3_stall", {31'd0, stall_by_arbitrater}, 0);
        inst_cache_req = 0;
        @(negedge clk);
        chk("t1_c4_dok_pulse", {31'd0, inst_cache_dok}, 0);

        // Simultaneous requests: data served first, stall held until inst done.
        @(negedge clk);
        issue(1, 32'h8000_1000, 0, 2'b10, 0, 0, rd_model(32'h8000_1000));
        issue(0, 32'hBFC0_0004, 0, 2'b10, 0, 0, rd_model(32'hBFC0_0004));
        bad_stall = 0; got = 0; seen_data = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (data_cache_dok) seen_data = 1;
            if (inst_cache_dok) got = 1;
            else if (!stall_by_arbitrater) bad_stall++;
        end
        chk("t2_inst_dok_seen", {31'd0, got}, 1);
        chk("t2_data_dok_first", {31'd0, seen_data}, 1);
        chk("t2_stall_held", bad_stall, 0);
        chk("t2_stall_low_at_inst_dok", {31'd0, stall_by_arbitrater}, 0);
        inst_cache_req = 0; data_cache_req = 0;

        // Byte write with delayed B.
        b_wait = 3;
        @(negedge clk);
        issue(1, 32'h8000_0003, 1, 2'b00, 32'hAB00_0000, 4'b1000, 0);
        wait_dok(1, 20, at);
`ifndef CACHE_AXI_EARLY_WACK_EN
        chk("t3_dok_after_b", at, last_b_cyc + 1);
`endif
        data_cache_req = 0;
        b_wait = 0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            issue(1, wr_addr[i], 1, wr_size[i], 32'h1122_3344 + i, wr_strb[i], 0);
            wait_dok(1, 20, at);
            data_cache_req = 0;
        end

        // Slave stalls arready for five cycles.
        ar_wait = 5;
        @(negedge clk);
        issue(0, 32'hBFC0_0010, 0, 2'b10, 0, 0, rd_model(32'hBFC0_0010));
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            chk("t5_arvalid_held", {31'd0, arvalid}, 1);
            chk("t5_araddr_stable", araddr, 32'hBFC0_0010);
            chk("t5_stall_high", {31'd0, stall_by_arbitrater}, 1);
        end
        wait_dok(0, 10, at);
        inst_cache_req = 0;
        ar_wait = 0;

`ifdef CACHE_AXI_EARLY_WACK_EN
        b_wait = 4;
        @(negedge clk);
        issue(1, 32'h8000_0020, 1, 2'b10, 32'h1234_5678, 4'b1111, 0);
        issue(0, 32'hBFC0_0020, 0, 2'b10, 0, 0, rd_model(32'hBFC0_0020));
        wait_dok(1, 20, at_w);
        wait_dok(0, 40, at);
        chk("t6_wdok_before_b", {31'd0, at_w < last_b_cyc}, 1);
        chk("t6_ar_after_b", {31'd0, last_ar_cyc > last_b_cyc}, 1);
        inst_cache_req = 0; data_cache_req = 0;
        b_wait = 0;
`endif

        // Reset during RDATA abandons the read; a fresh read then completes.
        r_wait = 3;
        @(negedge clk);
        issue(0, 32'hBFC0_0030, 0, 2'b10, 0, 0, rd_model(32'hBFC0_0030));
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (rready) got = 1;
        end
        chk("t7_reached_rdata", {31'd0, got}, 1);
        resetn = 0; inst_cache_req = 0;
        exp_dok.delete();
        @(negedge clk);
        chk("t7_rst_rready", {31'd0, rready}, 0);
        chk("t7_rst_valids", {29'd0, arvalid, awvalid, wvalid}, 0);
        chk("t7_rst_dok", {30'd0, inst_cache_dok, data_cache_dok}, 0);
        chk("t7_rst_inst_rdata", inst_cache_rdata, 0);
        chk("t7_rst_data_rdata", data_cache_rdata, 0);
        chk("t7_rst_stall", {31'd0, stall_by_arbitrater}, 0);
        @(negedge clk);
        resetn = 1; r_wait = 0;
        @(negedge clk);
        issue(0, 32'hBFC0_0040, 0, 2'b10, 0, 0, rd_model(32'hBFC0_0040));
        wait_dok(0, 10, at);
        chk("t7_after_rst_rdata", inst_cache_rdata, rd_model(32'hBFC0_0040));
        inst_cache_req = 0;

        repeat (3) @(negedge clk);
        chk("sb_ar_drained", exp_ar.size(), 0);
        chk("sb_w_drained", exp_w.size(), 0);
        chk("sb_dok_drained", exp_dok.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
